// File: rtl/krnl_ctrl_s_axi_param.sv
// AXI4-Lite control slave for RTL kernels: CTRL/GIE/IER/ISR plus N scalar and M pointer arguments.
// R data registered on AR (rvalid next cycle); B/R hold until bready/rready, one transaction in flight per channel.
module krnl_ctrl_s_axi_param #(
    parameter int C_ADDR_WIDTH  = 12,
    parameter int C_DATA_WIDTH  = 32,
    parameter int C_NUM_SCALARS = 1,
    parameter int C_NUM_PTRS    = 2
) (
    input  logic                    aclk,
    input  logic                    areset_n,
    input  logic                    aclk_en,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [C_ADDR_WIDTH-1:0] awaddr,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [31:0]             wdata,
    input  logic [3:0]              wstrb,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [1:0]              bresp,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [C_ADDR_WIDTH-1:0] araddr,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [31:0]             rdata,
    output logic [1:0]              rresp,
    output logic                    interrupt,
    output logic                    ap_start,
    output logic                    ap_continue,
    input  logic                    ap_idle,
    input  logic                    ap_done,
    input  logic                    ap_ready,
    output logic [((C_NUM_SCALARS > 0) ? 32*C_NUM_SCALARS : 32)-1:0] scalars,
    output logic [((C_NUM_PTRS > 0) ? 64*C_NUM_PTRS : 64)-1:0]       ptrs
);
    localparam int NS     = C_NUM_SCALARS;
    localparam int NP     = C_NUM_PTRS;
    localparam int AW     = C_ADDR_WIDTH;
    localparam int WI     = AW - 2;
    localparam int SW     = (NS > 0) ? 32*NS : 32;
    localparam int PW     = (NP > 0) ? 64*NP : 64;
    localparam int NWORDS = 4 + 2*(NS + NP);

    if (C_DATA_WIDTH != 32) begin : g_bad_dw
        $error("krnl_ctrl_s_axi_param: C_DATA_WIDTH must be 32");
    end
    if ((1 << AW) < 4*NWORDS || NS > 16 || NP > 16 || NS < 0 || NP < 0) begin : g_bad_map
        $error("krnl_ctrl_s_axi_param: argument count or address width out of range");
    end

    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    logic [1:0]    wstate_q, wstate_d, rstate_q, rstate_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [1:0]    bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          start_q, start_d, done_q, done_d, ready_q, ready_d;
    logic          auto_q, auto_d, cont_q, cont_d, gie_q, gie_d, irq_q, irq_d;
    logic [1:0]    ier_q, ier_d, isr_q, isr_d;
    logic [SW-1:0] scalars_q, scalars_d;
    logic [PW-1:0] ptrs_q, ptrs_d;

    logic          wr_hs, wr_ok, ar_hs, rd_ok;
    logic          ctrl_we, gie_we, ier_we, isr_we, ctrl_rd;
    logic [WI-1:0] wwi, rwi;
    logic [31:0]   rd_val;

    // Every aligned word below the end of the argument area is mapped; reserved words read 0.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a[1:0] == 2'b00) && (a[AW-1:2] < WI'(NWORDS));
    endfunction

    assign wwi     = waddr_q[AW-1:2];
    assign rwi     = araddr[AW-1:2];
    assign wr_hs   = (wstate_q == ST_DATA) && wvalid;
    assign wr_ok   = addr_ok(waddr_q);
    assign ar_hs   = (rstate_q == ST_IDLE) && arvalid;
    assign rd_ok   = addr_ok(araddr);
    assign ctrl_we = wr_hs && wr_ok && wstrb[0] && (wwi == WI'(0));
    assign gie_we  = wr_hs && wr_ok && wstrb[0] && (wwi == WI'(1));
    assign ier_we  = wr_hs && wr_ok && wstrb[0] && (wwi == WI'(2));
    assign isr_we  = wr_hs && wr_ok && wstrb[0] && (wwi == WI'(3));
    assign ctrl_rd = ar_hs && rd_ok && (rwi == WI'(0));

    always_comb begin
        rd_val = 32'h0;
        case (rwi)
            WI'(0): rd_val = {24'h0, auto_q, 3'b000, ready_q, ap_idle, done_q, start_q};
            WI'(1): rd_val = {31'h0, gie_q};
            WI'(2): rd_val = {30'h0, ier_q};
            WI'(3): rd_val = {30'h0, isr_q};
            default: rd_val = 32'h0;
        endcase
        for (int i = 0; i < NS; i++)
            if (rwi == WI'(4 + 2*i)) rd_val = scalars_q[32*i +: 32];
        for (int j = 0; j < NP; j++) begin
            if (rwi == WI'(4 + 2*NS + 2*j)) rd_val = ptrs_q[64*j +: 32];
            if (rwi == WI'(5 + 2*NS + 2*j)) rd_val = ptrs_q[64*j+32 +: 32];
        end
        if (!rd_ok) rd_val = 32'h0;
    end

    always_comb begin
        start_d = start_q;
        if (ctrl_we && wdata[0])     start_d = 1'b1;
        else if (ap_ready && !auto_q) start_d = 1'b0;
        auto_d  = ctrl_we ? wdata[7] : auto_q;
        // A completion pulse and a clear-on-read in the same cycle: the pulse survives.
        done_d  = ap_done  | (done_q  & ~ctrl_rd);
        ready_d = ap_ready | (ready_q & ~ctrl_rd);
        cont_d  = (ctrl_we && wdata[4]) || (ap_done && auto_q);
        gie_d   = gie_we ? wdata[0] : gie_q;
        ier_d   = ier_we ? wdata[1:0] : ier_q;
        isr_d[0] = (ap_done  & ier_q[0]) | (isr_q[0] ^ (isr_we & wdata[0]));
        isr_d[1] = (ap_ready & ier_q[1]) | (isr_q[1] ^ (isr_we & wdata[1]));
        irq_d   = gie_q & (|isr_q);

        scalars_d = scalars_q;
        ptrs_d    = ptrs_q;
        if (wr_hs && wr_ok) begin
            for (int i = 0; i < NS; i++)
                if (wwi == WI'(4 + 2*i))
                    for (int b = 0; b < 4; b++)
                        if (wstrb[b]) scalars_d[32*i + 8*b +: 8] = wdata[8*b +: 8];
            for (int j = 0; j < NP; j++)
                for (int b = 0; b < 4; b++) begin
                    if (wstrb[b] && wwi == WI'(4 + 2*NS + 2*j)) ptrs_d[64*j + 8*b +: 8] = wdata[8*b +: 8];
                    if (wstrb[b] && wwi == WI'(5 + 2*NS + 2*j)) ptrs_d[64*j + 32 + 8*b +: 8] = wdata[8*b +: 8];
                end
        end

        wstate_d = wstate_q;
        waddr_d  = waddr_q;
        bresp_d  = bresp_q;
        case (wstate_q)
            ST_RESET: wstate_d = ST_IDLE;
            ST_IDLE:  if (awvalid) begin wstate_d = ST_DATA; waddr_d = awaddr; end
            ST_DATA:  if (wvalid) begin wstate_d = ST_RESP; bresp_d = wr_ok ? 2'b00 : 2'b10; end
            default:  if (bready) wstate_d = ST_IDLE;
        endcase

        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        case (rstate_q)
            ST_RESET: rstate_d = ST_IDLE;
            ST_IDLE:  if (arvalid) begin rstate_d = ST_DATA; rdata_d = rd_val; rresp_d = rd_ok ? 2'b00 : 2'b10; end
            default:  if (rready) rstate_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            wstate_q <= ST_RESET;  rstate_q <= ST_RESET;
            waddr_q  <= '0;        bresp_q  <= 2'b00;
            rresp_q  <= 2'b00;     rdata_q  <= 32'h0;
            start_q  <= 1'b0;      done_q   <= 1'b0;
            ready_q  <= 1'b0;      auto_q   <= 1'b0;
            cont_q   <= 1'b0;      gie_q    <= 1'b0;
            irq_q    <= 1'b0;      ier_q    <= 2'b00;
            isr_q    <= 2'b00;     scalars_q <= '0;
            ptrs_q   <= '0;
        end else if (aclk_en) begin
            wstate_q <= wstate_d;  rstate_q <= rstate_d;
            waddr_q  <= waddr_d;   bresp_q  <= bresp_d;
            rresp_q  <= rresp_d;   rdata_q  <= rdata_d;
            start_q  <= start_d;   done_q   <= done_d;
            ready_q  <= ready_d;   auto_q   <= auto_d;
            cont_q   <= cont_d;    gie_q    <= gie_d;
            irq_q    <= irq_d;     ier_q    <= ier_d;
            isr_q    <= isr_d;     scalars_q <= scalars_d;
            ptrs_q   <= ptrs_d;
        end
    end

    assign awready     = (wstate_q == ST_IDLE);
    assign wready      = (wstate_q == ST_DATA);
    assign bvalid      = (wstate_q == ST_RESP);
    assign bresp       = bresp_q;
    assign arready     = (rstate_q == ST_IDLE);
    assign rvalid      = (rstate_q == ST_DATA);
    assign rdata       = rdata_q;
    assign rresp       = rresp_q;
    assign interrupt   = irq_q;
    assign ap_start    = start_q;
    assign ap_continue = cont_q;
    assign scalars     = scalars_q;
    assign ptrs        = ptrs_q;
endmodule

// File: tb/tb_krnl_ctrl_s_axi_param.sv
// Bench for krnl_ctrl_s_axi_param with two scalars and two pointers; AXI responses go through a scoreboard queue.
module tb_krnl_ctrl_s_axi_param;
    logic        aclk = 1'b0;
    logic        areset_n, aclk_en;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [11:0] awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        interrupt, ap_start, ap_continue, ap_idle, ap_done, ap_ready;
    logic [63:0]  scalars;
    logic [127:0] ptrs;

    int vectors = 0;
    int miscompares = 0;
    int cont_cnt = 0;
    int cont_base;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;
    exp_t sb[$];

    krnl_ctrl_s_axi_param #(
        .C_ADDR_WIDTH(12), .C_DATA_WIDTH(32), .C_NUM_SCALARS(2), .C_NUM_PTRS(2)
    ) dut (
        .aclk(aclk), .areset_n(areset_n), .aclk_en(aclk_en),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .interrupt(interrupt), .ap_start(ap_start), .ap_continue(ap_continue),
        .ap_idle(ap_idle), .ap_done(ap_done), .ap_ready(ap_ready),
        .scalars(scalars), .ptrs(ptrs)
    );

    always #5 aclk = ~aclk;

    always @(negedge aclk) if (ap_continue === 1'b1) cont_cnt++;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic axi_wr(input string tag, input logic [11:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] exp_resp, input bit coinc_done);
        exp_t e;
        int n;
        e.data = 32'h0;
        e.resp = exp_resp;
        sb.push_back(e);
        @(negedge aclk);
        awvalid = 1'b1; awaddr = addr; wvalid = 1'b1; wdata = data; wstrb = strb;
        n = 0;
        while (!awready && n < 50) begin @(negedge aclk); n++; end
        chk_eq({tag, "_awready"}, awready, 1);
        @(negedge aclk);
        awvalid = 1'b0;
        n = 0;
        while (!wready && n < 50) begin @(negedge aclk); n++; end
        chk_eq({tag, "_wready"}, wready, 1);
        if (coinc_done) ap_done = 1'b1;
        @(negedge aclk);
        wvalid = 1'b0; ap_done = 1'b0; bready = 1'b1;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge aclk); n++; end
        e = sb.pop_front();
        chk_eq({tag, "_bresp"}, {bvalid, bresp}, {1'b1, e.resp});
        @(negedge aclk);
        bready = 1'b0;
    endtask

    task automatic axi_rd(input string tag, input logic [11:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp);
        exp_t e;
        int n;
        e.data = exp_data;
        e.resp = exp_resp;
        sb.push_back(e);
        @(negedge aclk);
        arvalid = 1'b1; araddr = addr;
        n = 0;
        while (!arready && n < 50) begin @(negedge aclk); n++; end
        @(negedge aclk);
        arvalid = 1'b0; rready = 1'b1;
        n = 0;
        while (!rvalid && n < 50) begin @(negedge aclk); n++; end
        e = sb.pop_front();
        chk_eq({tag, "_rdata"}, {rvalid, rdata}, {1'b1, e.data});
        chk_eq({tag, "_rresp"}, rresp, e.resp);
        @(negedge aclk);
        rready = 1'b0;
    endtask

    task automatic pulse_ready();
        @(negedge aclk); ap_ready = 1'b1;
        @(negedge aclk); ap_ready = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge aclk); ap_done = 1'b1;
        @(negedge aclk); ap_done = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge aclk);
        areset_n = 1'b1;
        chk_eq("awready_at_release", awready, 0);
        @(negedge aclk);
        chk_eq("awready_cycle1", awready, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        areset_n = 1'b0; aclk_en = 1'b1;
        awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wdata = '0; wstrb = '0; bready = 1'b0;
        arvalid = 1'b0; araddr = '0; rready = 1'b0;
        ap_idle = 1'b1; ap_done = 1'b0; ap_ready = 1'b0;
        repeat (3) @(negedge aclk);
        chk_eq("rst_outputs", {ap_start, ap_continue, interrupt, bvalid, rvalid, bresp, rresp}, 0);
        chk_eq("rst_rdata", rdata, 0);
        chk_eq("rst_scalars", scalars, 0);
        chk_eq("rst_ptrs_lo", ptrs[63:0], 0);
        chk_eq("rst_ptrs_hi", ptrs[127:64], 0);
        release_reset();
        axi_rd("ctrl_idle", 12'h000, 32'h0000_0004, 2'b00);

        axi_wr("wr_s1", 12'h018, 32'hDEAD_BEEF, 4'hF, 2'b00, 0);
        chk_eq("scalar1", scalars[63:32], 64'hDEAD_BEEF);
        axi_wr("wr_p0hi", 12'h024, 32'h1, 4'hF, 2'b00, 0);
        axi_wr("wr_p0lo", 12'h020, 32'h2, 4'hF, 2'b00, 0);
        chk_eq("ptr0", ptrs[63:0], 64'h0000_0001_0000_0002);
        axi_rd("rd_s1", 12'h018, 32'hDEAD_BEEF, 2'b00);
        axi_rd("rd_p0lo", 12'h020, 32'h2, 2'b00);
        axi_rd("rd_p0hi", 12'h024, 32'h1, 2'b00);
        axi_rd("rd_rsvd", 12'h014, 32'h0, 2'b00);
        axi_rd("rd_past_end", 12'h030, 32'h0, 2'b10);
        axi_wr("wr_strb", 12'h010, 32'hAABB_CCDD, 4'b0101, 2'b00, 0);
        chk_eq("scalar0_strb", scalars[31:0], 64'h00BB_00DD);

        // Single-shot start, completion bits cleared on read.
        axi_wr("ctrl_start", 12'h000, 32'h1, 4'h1, 2'b00, 0);
        chk_eq("ap_start_set", ap_start, 1);
        ap_idle = 1'b0;
        pulse_ready();
        chk_eq("ap_start_drop", ap_start, 0);
        pulse_done();
        axi_rd("ctrl_cor1", 12'h000, 32'h0000_000A, 2'b00);
        axi_rd("ctrl_cor2", 12'h000, 32'h0000_0000, 2'b00);

        // Interrupts.
        axi_wr("gie", 12'h004, 32'h1, 4'h1, 2'b00, 0);
        axi_wr("ier", 12'h008, 32'h3, 4'h1, 2'b00, 0);
        pulse_done();
        @(negedge aclk);
        chk_eq("irq_on_done", interrupt, 1);
        axi_wr("isr_clr", 12'h00C, 32'h1, 4'h1, 2'b00, 0);
        chk_eq("irq_after_clr", interrupt, 0);
        pulse_done();
        axi_wr("isr_race", 12'h00C, 32'h1, 4'h1, 2'b00, 1);
        axi_rd("isr_after_race", 12'h00C, 32'h1, 2'b00);
        chk_eq("irq_after_race", interrupt, 1);

        // Auto-restart.
        axi_wr("ctrl_auto", 12'h000, 32'h81, 4'h1, 2'b00, 0);
        cont_base = cont_cnt;
        for (int k = 0; k < 2; k++) begin
            pulse_ready();
            chk_eq("auto_start_held", ap_start, 1);
            pulse_done();
            @(negedge aclk);
        end
        chk_eq("auto_cont_pulses", cont_cnt - cont_base, 2);
        axi_rd("ctrl_auto1", 12'h000, 32'h0000_008B, 2'b00);
        axi_rd("ctrl_auto2", 12'h000, 32'h0000_0081, 2'b00);
        cont_base = cont_cnt;
        axi_wr("ctrl_cont", 12'h000, 32'h90, 4'h1, 2'b00, 0);
        chk_eq("host_cont_pulse", cont_cnt - cont_base, 1);
        axi_wr("ctrl_auto_off", 12'h000, 32'h0, 4'h1, 2'b00, 0);
        chk_eq("start_kept", ap_start, 1);
        pulse_ready();
        chk_eq("start_cleared", ap_start, 0);
        axi_rd("ctrl_ready", 12'h000, 32'h0000_0008, 2'b00);

        // Pulses while the clock enable is low are dropped.
        @(negedge aclk); aclk_en = 1'b0; ap_done = 1'b1;
        @(negedge aclk); ap_done = 1'b0; aclk_en = 1'b1;
        axi_rd("ctrl_gated", 12'h000, 32'h0000_0000, 2'b00);

        axi_rd("rd_unmapped", 12'h7F0, 32'h0, 2'b10);
        axi_wr("wr_unmapped", 12'h7F0, 32'hFFFF_FFFF, 4'hF, 2'b10, 0);
        chk_eq("unmapped_no_effect", scalars, 64'hDEAD_BEEF_00BB_00DD);

        // Reset during the data phase must not commit the write.
        @(negedge aclk);
        awvalid = 1'b1; awaddr = 12'h018;
        @(negedge aclk);
        awvalid = 1'b0;
        chk_eq("abort_in_data", wready, 1);
        wvalid = 1'b1; wdata = 32'h1234_5678; wstrb = 4'hF; areset_n = 1'b0;
        @(negedge aclk);
        wvalid = 1'b0;
        chk_eq("abort_scalar1", scalars[63:32], 0);
        chk_eq("abort_bvalid", bvalid, 0);
        ap_idle = 1'b1;
        release_reset();
        axi_rd("ctrl_after_abort", 12'h000, 32'h0000_0004, 2'b00);
        axi_rd("s1_after_abort", 12'h018, 32'h0, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
